// File: rtl/cpu_pkg.sv
// Shared types and constants for the pipeline write-back stage and register file.
package cpu_pkg;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] word_t;

  localparam reg_addr_t REG_ZERO       = 5'd0;
  localparam word_t     RST_PC_DEFAULT = 32'h0;

endpackage

// File: rtl/wb_regfile_if.sv
// Write-back bundle, decode read ports and retire/trace outputs of wb_regfile.
// Trace signals exist only when WB_TRACE_EN is defined.
interface wb_regfile_if;
  import cpu_pkg::*;

  word_t     pc_wb;
  word_t     wdata_wb;
  reg_addr_t waddr_wb;
  logic [2:0] tnew_wb;
  reg_addr_t rs_addr;
  reg_addr_t rt_addr;
  word_t     rs_data;
  word_t     rt_data;
  word_t     instret;
`ifdef WB_TRACE_EN
  logic      trace_valid;
  word_t     trace_pc;
  reg_addr_t trace_reg;
  word_t     trace_data;
`endif

  modport master (
    output pc_wb, wdata_wb, waddr_wb, tnew_wb, rs_addr, rt_addr,
`ifdef WB_TRACE_EN
    input  trace_valid, trace_pc, trace_reg, trace_data,
`endif
    input  rs_data, rt_data, instret
  );

  modport slave (
    input  pc_wb, wdata_wb, waddr_wb, tnew_wb, rs_addr, rt_addr,
`ifdef WB_TRACE_EN
    output trace_valid, trace_pc, trace_reg, trace_data,
`endif
    output rs_data, rt_data, instret
  );

endinterface

// File: rtl/wb_trace.sv
// Registered write-back trace: one beat per committed register write, all-zero otherwise.
module wb_trace
  import cpu_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      we,
  input  word_t     pc,
  input  reg_addr_t waddr,
  input  word_t     wdata,
  output logic      trace_valid,
  output word_t     trace_pc,
  output reg_addr_t trace_reg,
  output word_t     trace_data
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      trace_valid <= 1'b0;
      trace_pc    <= '0;
      trace_reg   <= '0;
      trace_data  <= '0;
    end else begin
      trace_valid <= we;
      trace_pc    <= we ? pc    : '0;
      trace_reg   <= we ? waddr : '0;
      trace_data  <= we ? wdata : '0;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage and 32x32 register file with write-through bypass and retire counter.
// Optional registered trace output enabled by macro WB_TRACE_EN.
module wb_regfile
  import cpu_pkg::*;
#(
  parameter int    NREG   = 32,
  parameter word_t RST_PC = RST_PC_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  wb_regfile_if.slave  bus
);

  logic  we;
  word_t regs [NREG];
  word_t instret_q;

  // A nonzero tnew in WB is a pipeline bug; the write is dropped but retirement still counts.
  assign we = (bus.waddr_wb != REG_ZERO) && (bus.tnew_wb == 3'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      instret_q <= '0;
    end else begin
      if (we && (int'(bus.waddr_wb) < NREG)) regs[bus.waddr_wb] <= bus.wdata_wb;
      if (bus.pc_wb != RST_PC) instret_q <= instret_q + 32'd1;
    end
  end

  function automatic word_t read_port(reg_addr_t addr);
    word_t val;
    val = '0;
    if (addr == REG_ZERO)                    val = '0;
    else if (we && (bus.waddr_wb == addr))   val = bus.wdata_wb;
    else if (int'(addr) < NREG)              val = regs[addr];
    return val;
  endfunction

  assign bus.rs_data = read_port(bus.rs_addr);
  assign bus.rt_data = read_port(bus.rt_addr);
  assign bus.instret = instret_q;

`ifdef WB_TRACE_EN
  logic      trace_valid;
  word_t     trace_pc;
  reg_addr_t trace_reg;
  word_t     trace_data;

  wb_trace u_trace (
    .clk         (clk),
    .reset       (reset),
    .we          (we),
    .pc          (bus.pc_wb),
    .waddr       (bus.waddr_wb),
    .wdata       (bus.wdata_wb),
    .trace_valid (trace_valid),
    .trace_pc    (trace_pc),
    .trace_reg   (trace_reg),
    .trace_data  (trace_data)
  );

  assign bus.trace_valid = trace_valid;
  assign bus.trace_pc    = trace_pc;
  assign bus.trace_reg   = trace_reg;
  assign bus.trace_data  = trace_data;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; trace checks compile only with WB_TRACE_EN.
module tb_wb_regfile;
  import cpu_pkg::*;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  wb_regfile_if bus ();

  wb_regfile dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input word_t pc, input reg_addr_t wa, input word_t wd, input logic [2:0] tn);
    bus.pc_wb    = pc;
    bus.waddr_wb = wa;
    bus.wdata_wb = wd;
    bus.tnew_wb  = tn;
  endtask

  task automatic bubble();
    drive(RST_PC_DEFAULT, 5'd0, 32'h0, 3'd0);
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b0;
    bus.rs_addr = 5'd8;
    bus.rt_addr = 5'd0;
    drive(32'h100, 5'd8, 32'h1234, 3'd0);
    next_cycle();
    next_cycle();
    reset = 1'b1;
    bubble();
    #1;
    chk("reset_rs8", bus.rs_data, 32'h0);
    chk("reset_instret", bus.instret, 32'h0);
`ifdef WB_TRACE_EN
    chk("reset_trace_valid", {31'h0, bus.trace_valid}, 32'h0);
`endif

    // write then read
    next_cycle();
    drive(32'h3000, 5'd5, 32'hDEADBEEF, 3'd0);
    bus.rs_addr = 5'd5;
    #1;
    chk("bypass_rs5", bus.rs_data, 32'hDEADBEEF);
    next_cycle();
    bubble();
    #1;
    chk("stored_rs5", bus.rs_data, 32'hDEADBEEF);
    chk("instret_1", bus.instret, 32'd1);
`ifdef WB_TRACE_EN
    chk("trace1_valid", {31'h0, bus.trace_valid}, 32'h1);
    chk("trace1_pc", bus.trace_pc, 32'h3000);
    chk("trace1_reg", {27'h0, bus.trace_reg}, 32'd5);
    chk("trace1_data", bus.trace_data, 32'hDEADBEEF);
`endif

    // write to register 0
    drive(32'h3004, 5'd0, 32'hFFFFFFFF, 3'd0);
    bus.rs_addr = 5'd0;
    bus.rt_addr = 5'd0;
    #1;
    chk("r0_rs", bus.rs_data, 32'h0);
    chk("r0_rt", bus.rt_data, 32'h0);
    next_cycle();
    bubble();
    #1;
    chk("r0_instret", bus.instret, 32'd2);
`ifdef WB_TRACE_EN
    chk("r0_trace_valid", {31'h0, bus.trace_valid}, 32'h0);
`endif

    // bubbles, then blocked write
    next_cycle();
    next_cycle();
    next_cycle();
    chk("bubble_instret", bus.instret, 32'd2);
    drive(32'h3008, 5'd9, 32'h55, 3'd1);
    bus.rs_addr = 5'd9;
    #1;
    chk("blocked_bypass_rs9", bus.rs_data, 32'h0);
    next_cycle();
    bubble();
    #1;
    chk("blocked_stored_rs9", bus.rs_data, 32'h0);
    chk("blocked_instret", bus.instret, 32'd3);
`ifdef WB_TRACE_EN
    chk("blocked_trace_valid", {31'h0, bus.trace_valid}, 32'h0);
`endif

    // back-to-back writes to register 3
    drive(32'h300C, 5'd3, 32'h1, 3'd0);
    bus.rs_addr = 5'd3;
    bus.rt_addr = 5'd3;
    #1;
    chk("b2b_rs_1", bus.rs_data, 32'h1);
    chk("b2b_rt_1", bus.rt_data, 32'h1);
    next_cycle();
    drive(32'h3010, 5'd3, 32'h2, 3'd0);
    #1;
    chk("b2b_rs_2", bus.rs_data, 32'h2);
    chk("b2b_rt_2", bus.rt_data, 32'h2);
`ifdef WB_TRACE_EN
    chk("b2b_trace1_valid", {31'h0, bus.trace_valid}, 32'h1);
    chk("b2b_trace1_reg", {27'h0, bus.trace_reg}, 32'd3);
    chk("b2b_trace1_data", bus.trace_data, 32'h1);
`endif
    next_cycle();
    bubble();
    #1;
    chk("b2b_stored_rs", bus.rs_data, 32'h2);
    chk("b2b_instret", bus.instret, 32'd5);
`ifdef WB_TRACE_EN
    chk("b2b_trace2_valid", {31'h0, bus.trace_valid}, 32'h1);
    chk("b2b_trace2_pc", bus.trace_pc, 32'h3010);
    chk("b2b_trace2_data", bus.trace_data, 32'h2);
`endif

    // bypass on one port while the other reads storage
    drive(32'h3014, 5'd5, 32'hCAFE0001, 3'd0);
    bus.rs_addr = 5'd5;
    bus.rt_addr = 5'd3;
    #1;
    chk("split_rs_bypass", bus.rs_data, 32'hCAFE0001);
    chk("split_rt_store", bus.rt_data, 32'h2);
    next_cycle();
    bubble();
    #1;
    chk("split_rs_stored", bus.rs_data, 32'hCAFE0001);
`ifdef WB_TRACE_EN
    next_cycle();
    chk("trace_idle_valid", {31'h0, bus.trace_valid}, 32'h0);
    chk("trace_idle_data", bus.trace_data, 32'h0);
`endif

    // counter wrap
    force dut.instret_q = 32'hFFFFFFFF;
    #1;
    release dut.instret_q;
    chk("wrap_preload", bus.instret, 32'hFFFFFFFF);
    drive(32'h3020, 5'd0, 32'h0, 3'd0);
    next_cycle();
    bubble();
    #1;
    chk("wrap_instret", bus.instret, 32'h0);

    // reset clears stored registers
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
    bus.rs_addr = 5'd5;
    bus.rt_addr = 5'd3;
    #1;
    chk("rereset_rs5", bus.rs_data, 32'h0);
    chk("rereset_rt3", bus.rt_data, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and general register file of the five-stage MIPS pipeline, sitting directly downstream of the MEM/WB pipeline register. It commits the write-back bundle (PC, result data, destination register) into a 32×32 register file and serves the two decode-stage read ports with same-cycle write-through bypass. It also counts retired instructions and, optionally, emits a registered write-back trace for the test bench.

## Interface
Parameters:
- `NREG`, 32, number of architectural registers; the address width is fixed at 5 bits.
- `RST_PC`, 32'h0, PC value that marks a bubble and is never counted as retired.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset (asserted when 0).
- `pc_wb`  in  32  PC of the instruction in WB; `RST_PC` indicates a bubble or flushed slot.
- `wdata_wb`  in  32  result data to commit.
- `waddr_wb`  in  5  destination register; 0 means no write.
- `tnew_wb`  in  3  remaining latency; must be 0 in WB. Any nonzero value blocks the write.
- `rs_addr`, `rt_addr`  in  5  decode-stage read addresses.
- `rs_data`, `rt_data`  out  32  combinational read data, with bypass applied.
- `instret`  out  32  count of retired instructions.
- `trace_valid`  out  1  trace strobe. Present only with `WB_TRACE_EN`.
- `trace_pc`  out  32  trace PC. Present only with `WB_TRACE_EN`.
- `trace_reg`  out  5  trace destination register. Present only with `WB_TRACE_EN`.
- `trace_data`  out  32  trace data. Present only with `WB_TRACE_EN`.

## Operation
- Write enable: `we = (waddr_wb != 0) && (tnew_wb == 0)`.
  - When `we` is set, `regs[waddr_wb] <= wdata_wb` at the next rising edge.
  - Register 0 reads 0 at all times. No storage is written for address 0.
- Read path for `rs_data` (same rule for `rt_data`):
  - If `rs_addr == 0`, output 0.
  - Otherwise, if `we` is set and `waddr_wb == rs_addr`, output `wdata_wb` (write-through bypass).
  - Otherwise, output `regs[rs_addr]`.
  - Both ports may hit the bypass in the same cycle.
- Retire counter: `instret` increments by 1 on every clock edge where `pc_wb != RST_PC`.
  - A retired instruction need not write a register (stores and branches still count).
  - The counter wraps from 32'hFFFF_FFFF to 0 with no flag.
- Reset (`reset == 0` at an edge):
  - All registers and `instret` clear to 0.
  - Trace outputs clear to 0.
  - Any write or count presented in that cycle is discarded.
  - The cycle after reset deasserts behaves normally.
- `tnew_wb != 0` while in WB is a pipeline-control bug. The write is suppressed, but the retire count is still taken from `pc_wb`.

## Timing
- Write latency: the written data is visible in `regs` from the edge after it is presented. Through the bypass it is visible in the same cycle.
- Read ports are combinational, with zero latency from the address and bypass inputs.
- `instret` is registered: it reflects retirements up to and including the previous edge.
- Trace outputs are registered, one cycle after the WB bundle is presented:
  - `trace_valid` is high for exactly one cycle per enabled write.
  - All trace outputs are 0 whenever `trace_valid` is 0.
- Back-to-back writes to the same register: the later one wins, and each write produces its own trace beat.

## Configuration
- Macro `WB_TRACE_EN`.
- Defined: the four trace ports exist and are driven as described in Timing.
- Undefined: the trace ports and their flops are absent. Register-file and `instret` behaviour is identical in both builds.

## Structure
- Shared package `cpu_pkg` holds the following:
  - `REG_ZERO` (5'd0).
  - The `reg_addr_t` (5-bit) and `word_t` (32-bit) typedefs.
  - The `RST_PC` default.
- One sub-module, `wb_trace`: the registered trace stage, instantiated only under `WB_TRACE_EN`.
- All other logic lives in `wb_regfile`.

## Test plan
- Reset behaviour:
  - Stimulus: hold `reset=0` for 2 cycles while presenting a write of `waddr_wb=8`, `wdata_wb=32'h1234`.
  - Response: no write occurs; `rs_addr=8` reads 0; `instret=0`; `trace_valid=0`.
- Write then read:
  - Stimulus: write `waddr_wb=5`, `wdata_wb=32'hDEADBEEF`, `pc_wb=32'h3000`.
  - Response: `rs_data` reads DEADBEEF in the same cycle through the bypass and still reads it on the next cycle from storage; `instret` becomes 1.
- Writes to register 0:
  - Stimulus: write `waddr_wb=0`, `wdata_wb=32'hFFFF_FFFF` while `rs_addr=rt_addr=0`.
  - Response: both ports read 0; `trace_valid` stays 0; `instret` still increments.
- Bubble and blocked write:
  - Stimulus: present `pc_wb=RST_PC` for 3 cycles, then present `tnew_wb=1` with `waddr_wb=9`.
  - Response: `instret` is unchanged across the bubbles; register 9 is unchanged.
- Same-register writes and trace:
  - Stimulus: write register 3 with `32'h1` and then `32'h2` on consecutive cycles, with `rs_addr=rt_addr=3`.
  - Response: the ports read 1 then 2; two trace beats appear (`3/1`, then `3/2`), each one cycle later.
- Counter wrap:
  - Stimulus: preload `instret` to 32'hFFFF_FFFF by force, then retire one instruction.
  - Response: `instret` reads 0.
